axis_width_down: RTL and testbench

Parametrised AXI-Stream width downsizer that splits each `IN_W = RATIO*OUT_W` input word into `RATIO` output slices, least significant slice first. It is the general-purpose successor of the fixed 1536→128 data-route serializer, in the same position: between the wide systolic-array result bus and narrow DMA or stream sinks. It adds full throughput with no bubble between words, AXI-compliant stable `m_axis_tvalid`, `tlast` propagation, and partial last words.

---
 rtl/data_route_pkg.sv | 26 ++
 rtl/axis_width_down.sv | 82 ++++++++
 tb/tb_axis_width_down.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_route_pkg.sv
// Shared definitions for the data-route width converters (downsizer now, upsizer later).
package data_route_pkg;

    localparam int DEF_OUT_W = 128;
    localparam int DEF_RATIO = 12;

    // Occupancy of the converter: nothing held, or slices still to hand out.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_DRAIN = 1'b1
    } route_state_e;

    // Width of a slice-count field able to hold 0..ratio.
    function automatic int nb_width(input int ratio);
        return $clog2(ratio + 1);
    endfunction

    // A slice count of 0 means a full word; anything above ratio is capped at a full word.
    function automatic int clamp_nbeats(input int nbeats, input int ratio);
        if ((nbeats == 0) || (nbeats > ratio)) begin
            return ratio;
        end
        return nbeats;
    endfunction

endpackage

// File: rtl/axis_width_down.sv
// AXI-Stream width downsizer: each wide input word is handed out as RATIO narrow
// slices, least significant slice first, with optional short (partial) words.
module axis_width_down
    import data_route_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int RATIO = DEF_RATIO,
    parameter int NB_W  = nb_width(RATIO)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [RATIO*OUT_W-1:0] s_axis_tdata,
    input  logic                   s_axis_tvalid,
    input  logic                   s_axis_tlast,
    input  logic [NB_W-1:0]        s_axis_nbeats,
    output logic                   s_axis_tready,
    output logic [OUT_W-1:0]       m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready
);

    localparam int IN_W = RATIO * OUT_W;

    logic [IN_W-1:0] hold_q, hold_d;
    logic [NB_W-1:0] rem_q,  rem_d;
    logic            last_q, last_d;
    logic            accept;
    logic            consume;
    route_state_e    state;

    // The converter state is fully described by the remaining-slice count.
    assign state = (rem_q == '0) ? ST_EMPTY : ST_DRAIN;

    // The output slice is always the bottom of the holding register.
    assign m_axis_tdata = hold_q[OUT_W-1:0];
    assign m_axis_tlast = last_q && (rem_q == NB_W'(1));

    // Handshakes and next state: a new word may load on the same edge the final slice leaves.
    always_comb begin
        hold_d = hold_q;
        rem_d  = rem_q;
        last_d = last_q;

        m_axis_tvalid = (state == ST_DRAIN);
        s_axis_tready = !rst && ((state == ST_EMPTY) ||
                                 ((rem_q == NB_W'(1)) && m_axis_tready));
        accept  = s_axis_tvalid && s_axis_tready;
        consume = m_axis_tvalid && m_axis_tready;

        if (accept) begin
            hold_d = s_axis_tdata;
            rem_d  = NB_W'(clamp_nbeats(int'(s_axis_nbeats), RATIO));
            last_d = s_axis_tlast;
        end else if (consume) begin
            hold_d = hold_q >> OUT_W;
            rem_d  = rem_q - NB_W'(1);
        end
    end

    // State registers; reset discards any partially drained word.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            rem_q  <= '0;
            last_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            rem_q  <= rem_d;
            last_q <= last_d;
        end
    end

    // A presented slice must not change or vanish until it is taken.
    assert property (@(posedge clk) disable iff (rst)
        (m_axis_tvalid && !m_axis_tready) |=>
        (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast)));

    // The slice counter never exceeds one full word.
    assert property (@(posedge clk) rem_q <= NB_W'(RATIO));

endmodule

// File: tb/tb_axis_width_down.sv
// Testbench for axis_width_down: directed cases plus a randomised scoreboard run.
module tb_axis_width_down;

    localparam int OUT_W = 128;
    localparam int RATIO = 12;
    localparam int IN_W  = RATIO * OUT_W;
    localparam int NB_W  = $clog2(RATIO + 1);

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic             last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [IN_W-1:0]  s_tdata;
    logic             s_tvalid;
    logic             s_tlast;
    logic [NB_W-1:0]  s_nbeats;
    logic             s_tready;
    logic [OUT_W-1:0] m_tdata;
    logic             m_tvalid;
    logic             m_tlast;
    logic             m_tready;

    beat_t sb[$];
    int    total = 0;
    int    bad   = 0;
    int    mode;
    logic  rdy_fix;

    always #5 clk = ~clk;

    axis_width_down #(.OUT_W(OUT_W), .RATIO(RATIO)) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tlast  (s_tlast),
        .s_axis_nbeats (s_nbeats),
        .s_axis_tready (s_tready),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tlast  (m_tlast),
        .m_axis_tready (m_tready)
    );

    task automatic chk(input string tag, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] seq_word(input int base);
        logic [IN_W-1:0] w;
        w = '0;
        for (int k = 0; k < RATIO; k++) w[k*OUT_W +: OUT_W] = OUT_W'(base + k);
        return w;
    endfunction

    // Scoreboard: push slices on accept, pop and compare on consume, watch stalled outputs.
    task automatic monitor();
        logic             stall = 1'b0;
        logic [OUT_W-1:0] pd = '0;
        logic             pl = 1'b0;
        beat_t            b;
        int               n;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("hold_valid", OUT_W'(m_tvalid), OUT_W'(1));
                    chk("hold_data", m_tdata, pd);
                    chk("hold_last", OUT_W'(m_tlast), OUT_W'(pl));
                end
                if (s_tvalid && s_tready) begin
                    n = ((s_nbeats == '0) || (int'(s_nbeats) > RATIO)) ? RATIO : int'(s_nbeats);
                    for (int k = 0; k < n; k++) begin
                        b.data = s_tdata[k*OUT_W +: OUT_W];
                        b.last = s_tlast && (k == n - 1);
                        sb.push_back(b);
                    end
                end
                if (m_tvalid && m_tready) begin
                    if (sb.size() == 0) begin
                        chk("extra_beat", OUT_W'(1), OUT_W'(0));
                    end else begin
                        b = sb.pop_front();
                        chk("beat_data", m_tdata, b.data);
                        chk("beat_last", OUT_W'(m_tlast), OUT_W'(b.last));
                    end
                end
                stall = m_tvalid && !m_tready;
                pd    = m_tdata;
                pl    = m_tlast;
            end
        end
    endtask

    // Output-side ready: fixed, the 1,0,0,1 stall pattern, or random.
    task automatic rdy_drv();
        int pi = 0;
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0:       m_tready = rdy_fix;
                1: begin
                    m_tready = ((pi % 4) == 0) || ((pi % 4) == 3);
                    pi++;
                end
                default: m_tready = ($urandom_range(0, 99) < 60);
            endcase
        end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send_word(input logic [IN_W-1:0] d, input int nb, input logic last);
        logic ok = 1'b0;
        s_tdata  = d;
        s_nbeats = NB_W'(nb);
        s_tlast  = last;
        s_tvalid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (s_tready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", OUT_W'(0), OUT_W'(1));
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
    endtask

    task automatic wait_drain(input int bound);
        logic done = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            #1;
            if ((sb.size() == 0) && !m_tvalid) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("drain_timeout", OUT_W'(0), OUT_W'(1));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int              cnt;
        int              word;
        logic            acc;
        logic [IN_W-1:0] d;

        rst      = 1'b1;
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
        s_nbeats = '0;
        m_tready = 1'b0;
        rdy_fix  = 1'b1;
        mode     = 0;
        fork
            monitor();
            rdy_drv();
        join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", OUT_W'(m_tvalid), OUT_W'(0));
        chk("rst_last", OUT_W'(m_tlast), OUT_W'(0));
        chk("rst_data", m_tdata, OUT_W'(0));
        chk("rst_rdy", OUT_W'(s_tready), OUT_W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rdy_after_rst", OUT_W'(s_tready), OUT_W'(1));
        @(posedge clk);
        #1;

        // Single full word, 12 consecutive beats, then idle
        send_word(seq_word(1), 0, 1'b1);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_tvalid) cnt++;
        end
        chk("t1_beats", OUT_W'(cnt), OUT_W'(12));
        @(negedge clk);
        chk("t1_idle_valid", OUT_W'(m_tvalid), OUT_W'(0));
        chk("t1_sb_empty", OUT_W'(sb.size()), OUT_W'(0));
        @(posedge clk);
        #1;

        // Two back-to-back words with no gap
        s_tdata  = seq_word(13 - 12);
        s_nbeats = '0;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        word     = 0;
        for (int c = 0; c < 26; c++) begin
            @(negedge clk);
            chk("t2_rdy", OUT_W'(s_tready), OUT_W'((c == 0) || (c == 12) || (c >= 24)));
            if ((c >= 1) && (c <= 24)) chk("t2_valid", OUT_W'(m_tvalid), OUT_W'(1));
            acc = s_tvalid && s_tready;
            @(posedge clk);
            #1;
            if (acc) begin
                if (word == 0) begin
                    s_tdata = seq_word(13);
                    s_tlast = 1'b1;
                    word    = 1;
                end else begin
                    s_tvalid = 1'b0;
                end
            end
        end
        chk("t2_sb_empty", OUT_W'(sb.size()), OUT_W'(0));

        // Stall pattern 1,0,0,1
        mode = 1;
        send_word(seq_word(1), 0, 1'b1);
        wait_drain(200);
        mode = 0;

        // Partial word of 3 slices, then a clamped nbeats of 15
        send_word(seq_word(10), 3, 1'b1);
        repeat (3) @(negedge clk);
        @(negedge clk);
        chk("t4_rdy", OUT_W'(s_tready), OUT_W'(1));
        chk("t4_valid", OUT_W'(m_tvalid), OUT_W'(0));
        @(posedge clk);
        #1;
        send_word(seq_word(100), 15, 1'b0);
        cnt = 0;
        repeat (13) begin
            @(negedge clk);
            if (m_tvalid) cnt++;
        end
        chk("t4_clamp_beats", OUT_W'(cnt), OUT_W'(12));
        @(posedge clk);
        #1;

        // Reset in the middle of a word
        send_word(seq_word(50), 0, 1'b1);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rdy_in_rst", OUT_W'(s_tready), OUT_W'(0));
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("t5_valid_rst", OUT_W'(m_tvalid), OUT_W'(0));
        chk("t5_last_rst", OUT_W'(m_tlast), OUT_W'(0));
        chk("t5_rdy_rst", OUT_W'(s_tready), OUT_W'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rdy_release", OUT_W'(s_tready), OUT_W'(1));
        @(posedge clk);
        #1;
        send_word(seq_word(200), 0, 1'b1);
        @(negedge clk);
        chk("t5_first_slice", m_tdata, OUT_W'(200));
        wait_drain(100);

        // Randomised valid/ready over 1000 words
        mode = 2;
        for (int w = 0; w < 1000; w++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < IN_W / 32; i++) d[i*32 +: 32] = $urandom();
            send_word(d, $urandom_range(0, RATIO), 1'($urandom_range(0, 1)));
        end
        mode    = 0;
        rdy_fix = 1'b1;
        wait_drain(200);
        chk("rand_sb_empty", OUT_W'(sb.size()), OUT_W'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
